// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry and FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4,
    CLEANUP    = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable reset level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: d -> meta -> q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle good-byte strobe, framing-error strobe
// and break handling that waits for the line to go idle before re-arming.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int              CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]   HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);
  localparam logic [2:0]      LAST_IDX = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic [2:0]           index, index_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [7:0]           rx_byte, rx_byte_nxt;
  logic                 dv, dv_nxt;
  logic                 ferr, ferr_nxt;
  logic                 active, active_nxt;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .d     (i_RX_Serial),
    .q     (rx_s)
  );

  // Frame state and datapath registers.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      count   <= {CW{1'b0}};
      index   <= 3'd0;
      shift   <= {DATA_BITS{1'b0}};
      rx_byte <= 8'h00;
      dv      <= 1'b0;
      ferr    <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      index   <= index_nxt;
      shift   <= shift_nxt;
      rx_byte <= rx_byte_nxt;
      dv      <= dv_nxt;
      ferr    <= ferr_nxt;
      active  <= active_nxt;
    end
  end

  // Next-state logic; the two strobes fall back to zero every cycle.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    index_nxt   = index;
    shift_nxt   = shift;
    rx_byte_nxt = rx_byte;
    dv_nxt      = 1'b0;
    ferr_nxt    = 1'b0;
    active_nxt  = active;
    case (state)
      IDLE: begin
        count_nxt = {CW{1'b0}};
        index_nxt = 3'd0;
        if (!rx_s) begin
          state_nxt  = START;
          active_nxt = 1'b1;
        end else begin
          active_nxt = 1'b0;
        end
      end
      START: begin
        if (count == HALF) begin
          if (!rx_s) begin
            count_nxt = {CW{1'b0}};
            state_nxt = DATA;
          end else begin
            state_nxt  = IDLE;
            active_nxt = 1'b0;
          end
        end else begin
          count_nxt = count + ONE;
        end
      end
      DATA: begin
        if (count == LAST) begin
          count_nxt = {CW{1'b0}};
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          if (index == LAST_IDX) begin
            index_nxt = 3'd0;
            state_nxt = STOP;
          end else begin
            index_nxt = index + 3'd1;
          end
        end else begin
          count_nxt = count + ONE;
        end
      end
      STOP: begin
        // Sampling mid-stop-bit leaves half a bit to absorb CLEANUP/IDLE before the next start.
        if (count == LAST) begin
          count_nxt = {CW{1'b0}};
          if (rx_s) begin
            rx_byte_nxt = shift;
            dv_nxt      = 1'b1;
            state_nxt   = CLEANUP;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK_WAIT;
          end
        end else begin
          count_nxt = count + ONE;
        end
      end
      BREAK_WAIT: begin
        if (rx_s) begin
          state_nxt = CLEANUP;
        end else begin
          state_nxt = BREAK_WAIT;
        end
      end
      CLEANUP: begin
        active_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        count_nxt  = {CW{1'b0}};
        index_nxt  = 3'd0;
        active_nxt = 1'b0;
      end
    endcase
  end

  assign o_RX_DV        = dv;
  assign o_RX_Byte      = rx_byte;
  assign o_RX_Active    = active;
  assign o_RX_Frame_Err = ferr;

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
- UART receiver, the receive-side counterpart of the team's 8N1 transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Synchronises the asynchronous serial line and qualifies the start bit at mid-bit.
- Samples each data bit and the stop bit at mid-bit; presents each good byte with a one-cycle valid pulse.
- Flags framing errors (bad stop bit, including line break) and waits for the line to return idle before re-arming.

Parameters:
- CLKS_PER_BIT, 217, i_Clock frequency / baud rate; legal range ≥ 4.

Ports:
- i_Clock  input  1  system clock
- i_Rst_L  input  1  asynchronous active-low reset
- i_RX_Serial  input  1  raw serial line, idle high, asynchronous to i_Clock
- o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a newly received good byte
- o_RX_Byte  output  8  last good byte; held until the next good byte
- o_RX_Active  output  1  high while a frame is being received
- o_RX_Frame_Err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Clock and reset: one clock, i_Clock. i_Rst_L is asynchronous and active-low.
- Reset values:
  - o_RX_DV, o_RX_Active, o_RX_Frame_Err = 0; o_RX_Byte = 8'h00.
  - Both synchroniser flops = 1; state = IDLE; counters = 0.
  - Reset asserted mid-frame aborts the frame with no DV and no error pulse.
- Synchroniser: two flops on i_RX_Serial, giving rx_s with 2-cycle latency. All FSM decisions use rx_s only.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT)+1.
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Bit index is 3 bits; shift register is 8 bits, shifts right with the new bit entering at bit 7.
- States:
  - IDLE:
    - count=0, index=0, o_RX_Active=0.
    - rx_s==0 → START, o_RX_Active←1.
  - START:
    - count increments until count==HALF, then rx_s is checked.
    - rx_s==0 → count←0, go DATA.
    - rx_s==1 → glitch: go IDLE, o_RX_Active←0, no pulse.
  - DATA:
    - count increments to CLKS_PER_BIT-1; at that count, sample rx_s into the shift register and set count←0.
    - index<7 → index+1, stay in DATA. index==7 → index←0, go STOP.
  - STOP:
    - count increments to CLKS_PER_BIT-1, then rx_s is sampled.
    - Sample 1 → o_RX_Byte←shift register, o_RX_DV←1, go CLEANUP.
    - Sample 0 → o_RX_Frame_Err←1, o_RX_Byte unchanged, go BREAK_WAIT.
  - BREAK_WAIT: hold until rx_s==1, then go CLEANUP. No further error pulses, however long the line stays low.
  - CLEANUP: one cycle; o_RX_Active←0; go IDLE.
  - Unused encodings → IDLE.
- Pulses: o_RX_DV and o_RX_Frame_Err default to 0 every cycle and are never high together.
- Latency: o_RX_DV rises 1 cycle after the stop-bit sample point, about mid-stop-bit plus 2 synchroniser cycles after the line edge.
- Back-to-back frames: because the sample point is mid-stop-bit, the CLEANUP+IDLE overhead is absorbed. A start edge that immediately follows the stop bit must be caught.
- Clock tolerance: frames from a transmitter up to ±2% off in clock must decode correctly.

Decomposition:
- Shared package uart_pkg:
  - state localparams: IDLE, START, DATA, STOP, BREAK_WAIT, CLEANUP (3-bit);
  - DATA_BITS = 8.
- One sub-module, uart_sync2: 2-flop synchroniser with parameterised reset value (1 for this use).
- Remaining RTL is a single FSM block.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
- Good byte: drive 8'hA5 framed 8N1 → exactly one o_RX_DV pulse; o_RX_Byte=8'hA5; o_RX_Frame_Err never high; o_RX_Active low within 2 cycles after the DV pulse.
- Start glitch: line low for 3 clocks, then high → o_RX_Active pulses; no DV; no Frame_Err; a following 8'h3C is received correctly.
- Bad stop: 8'h3C with stop bit low, after a prior good 8'h11 → one Frame_Err pulse; no DV; o_RX_Byte stays 8'h11. Then hold the line low for 20 bit times → no further pulses; return to IDLE once the line is high.
- Back-to-back: 8'h00 then 8'hFF with zero idle gap → two DV pulses, bytes 00 then FF in order.
- Reset mid-frame: assert i_Rst_L low during data bit 4 → all outputs reset at once. Then send 8'h5A → one DV pulse, byte 8'h5A.
- Loopback: connect the team transmitter (same CLKS_PER_BIT) to i_RX_Serial and send 0x00..0xFF → 256 DV pulses, each byte equal to the one sent, zero Frame_Err pulses. Repeat with the transmitter clock 2% fast and 2% slow.
